// File: rtl/spi_req_sequencer.sv
// spi_req_sequencer: two-port round-robin front end for spi_top's register bus.
// A granted one-byte request expands into configure, slave select, buffer load,
// settle, busy poll, buffer read, deselect and a one-cycle Ack on its port.
//
// state  | meaning
// INIT   | one-time CTRL enable write after reset
// IDLE   | arbitrate, latch winner's request fields
// CFG    | write CONFIG = {00, Mode, Pre}
// SSEL   | write SSELEC with the target select driven low
// LOAD   | write BUFFER = Tx (starts the SPI transfer)
// SETTLE | wait SETTLE_CYCLES before polling
// POLL   | read CTRL until busy clears or the timeout expires
// READ   | present BUFFER address
// CAP    | capture received byte
// DESEL  | write SSELEC = 0xFF
// DONE   | Ack (and Err) to owner, rotate priority
module spi_req_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [2:0] Slave0,
    input  logic [2:0] Slave1,
    input  logic [1:0] Mode0,
    input  logic [1:0] Mode1,
    input  logic [3:0] Pre0,
    input  logic [3:0] Pre1,
    input  logic [7:0] Tx0,
    input  logic [7:0] Tx1,
    output logic       Ack0,
    output logic       Ack1,
    output logic [7:0] Rx0,
    output logic [7:0] Rx1,
    output logic       Err0,
    output logic       Err1,
    output logic [1:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWr,
    input  logic [7:0] DataRd,
    output logic       Busy,
    output logic [1:0] Grant
);

    // spi_top register map (SPI_CTRL / SPI_CONFIG / SPI_SSELEC / SPI_BUFFER)
    localparam logic [1:0] SPI_CTRL   = 2'd0;
    localparam logic [1:0] SPI_CONFIG = 2'd1;
    localparam logic [1:0] SPI_SSELEC = 2'd2;
    localparam logic [1:0] SPI_BUFFER = 2'd3;

    localparam logic [7:0] CTRL_ENABLE = 8'h01;
    localparam logic [7:0] SSEL_NONE   = 8'hFF;

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_CFG,
        ST_SSEL,
        ST_LOAD,
        ST_SETTLE,
        ST_POLL,
        ST_READ,
        ST_CAP,
        ST_DESEL,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [2:0]    slave_q, slave_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    pre_q, pre_d;
    logic [7:0]    tx_q, tx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_buf_q, rx_buf_d;
    logic          err_flag_q, err_flag_d;

    logic          wr_q, wr_d;
    logic [1:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [7:0]    rx0_q, rx0_d;
    logic [7:0]    rx1_q, rx1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    // Next state, arbitration, request capture and the settle/timeout counters
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        slave_d    = slave_q;
        mode_d     = mode_q;
        pre_d      = pre_q;
        tx_d       = tx_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        rx_buf_d   = rx_buf_q;
        err_flag_d = err_flag_q;

        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (Req0 || Req1) begin
                    // port 0 wins unless port 1 alone asks or port 0 was served last
                    if (Req0 && (!Req1 || last_q)) begin
                        grant_d = 2'b01;
                        slave_d = Slave0;
                        mode_d  = Mode0;
                        pre_d   = Pre0;
                        tx_d    = Tx0;
                    end else begin
                        grant_d = 2'b10;
                        slave_d = Slave1;
                        mode_d  = Mode1;
                        pre_d   = Pre1;
                        tx_d    = Tx1;
                    end
                    rx_buf_d   = 8'h00;
                    err_flag_d = 1'b0;
                    state_d    = ST_CFG;
                end
            end
            ST_CFG:  state_d = ST_SSEL;
            ST_SSEL: state_d = ST_LOAD;
            ST_LOAD: begin
                settle_d = SETTLE_LOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    tmo_d   = '0;
                    state_d = ST_POLL;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_POLL: begin
                if (!DataRd[7]) begin
                    state_d = ST_READ;
                end else if (tmo_q >= TMO_LAST) begin
                    err_flag_d = 1'b1;
                    rx_buf_d   = 8'h00;
                    state_d    = ST_DESEL;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_READ: state_d = ST_CAP;
            ST_CAP: begin
                rx_buf_d = DataRd;
                state_d  = ST_DESEL;
            end
            ST_DESEL: state_d = ST_DONE;
            ST_DONE: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Bus and handshake values for the state about to be entered, so the
    // registered outputs line up with the state register
    always_comb begin
        wr_d   = 1'b0;
        addr_d = SPI_CTRL;
        data_d = 8'h00;
        busy_d = (state_d != ST_IDLE);
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        rx0_d  = rx0_q;
        rx1_d  = rx1_q;
        err0_d = err0_q;
        err1_d = err1_q;

        if (state_q == ST_INIT) begin
            wr_d   = 1'b1;
            data_d = CTRL_ENABLE;
        end else begin
            case (state_d)
                ST_CFG: begin
                    wr_d   = 1'b1;
                    addr_d = SPI_CONFIG;
                    data_d = {2'b00, mode_d, pre_d};
                end
                ST_SSEL: begin
                    wr_d   = 1'b1;
                    addr_d = SPI_SSELEC;
                    data_d = ~(8'b1 << slave_d);
                end
                ST_LOAD: begin
                    wr_d   = 1'b1;
                    addr_d = SPI_BUFFER;
                    data_d = tx_d;
                end
                ST_READ, ST_CAP: addr_d = SPI_BUFFER;
                ST_DESEL: begin
                    wr_d   = 1'b1;
                    addr_d = SPI_SSELEC;
                    data_d = SSEL_NONE;
                end
                ST_DONE: begin
                    ack0_d = grant_q[0];
                    ack1_d = grant_q[1];
                    if (grant_q[0]) begin
                        rx0_d  = rx_buf_d;
                        err0_d = err_flag_d;
                    end
                    if (grant_q[1]) begin
                        rx1_d  = rx_buf_d;
                        err1_d = err_flag_d;
                    end
                end
                default: ;
            endcase
        end
    end

    // All state, context and output registers; reset drops any transaction
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_INIT;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            slave_q    <= '0;
            mode_q     <= '0;
            pre_q      <= '0;
            tx_q       <= '0;
            settle_q   <= '0;
            tmo_q      <= '0;
            rx_buf_q   <= '0;
            err_flag_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rx0_q      <= '0;
            rx1_q      <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            slave_q    <= slave_d;
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            tx_q       <= tx_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            rx_buf_q   <= rx_buf_d;
            err_flag_q <= err_flag_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rx0_q      <= rx0_d;
            rx1_q      <= rx1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    assign Wr     = wr_q;
    assign Addr   = addr_q;
    assign DataWr = data_q;
    assign Busy   = busy_q;
    assign Grant  = grant_q;
    assign Ack0   = ack0_q;
    assign Ack1   = ack1_q;
    assign Rx0    = rx0_q;
    assign Rx1    = rx1_q;
    assign Err0   = err0_q;
    assign Err1   = err1_q;

endmodule

// File: tb/tb_spi_req_sequencer.sv
// Bench for spi_req_sequencer: a behavioural spi_top stand-in (loopback slave
// returning Tx ^ key after a programmable busy time) plus a transaction-level
// model of latency, arbitration order and register write sequence.
module tb_spi_req_sequencer;

    localparam int S = 2;
    localparam int T = 16;
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_CFG  = 2'd1;
    localparam logic [1:0] A_SS   = 2'd2;
    localparam logic [1:0] A_BUF  = 2'd3;

    logic       Clk, Rst;
    logic       Req0, Req1;
    logic [2:0] Slave0, Slave1;
    logic [1:0] Mode0, Mode1;
    logic [3:0] Pre0, Pre1;
    logic [7:0] Tx0, Tx1;
    logic       Ack0, Ack1;
    logic [7:0] Rx0, Rx1;
    logic       Err0, Err1;
    logic [1:0] Addr;
    logic       Wr;
    logic [7:0] DataWr, DataRd;
    logic       Busy;
    logic [1:0] Grant;

    int         checks = 0;
    int         failures = 0;
    int         busy_len = 1;
    bit         stuck = 0;
    logic [7:0] key = 8'h00;
    int         last_served = 1;
    logic [9:0] wlog[$];
    int         ack0_cnt = 0;
    int         ack1_cnt = 0;

    spi_req_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Req1(Req1),
        .Slave0(Slave0), .Slave1(Slave1),
        .Mode0(Mode0), .Mode1(Mode1),
        .Pre0(Pre0), .Pre1(Pre1),
        .Tx0(Tx0), .Tx1(Tx1),
        .Ack0(Ack0), .Ack1(Ack1),
        .Rx0(Rx0), .Rx1(Rx1),
        .Err0(Err0), .Err1(Err1),
        .Addr(Addr), .Wr(Wr), .DataWr(DataWr), .DataRd(DataRd),
        .Busy(Busy), .Grant(Grant)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // spi_top stand-in
    int         busy_cnt;
    logic [7:0] buf_q, cfg_q, ss_q;
    logic       en_q;
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy_cnt <= 0;
            buf_q    <= 8'h00;
            cfg_q    <= 8'h00;
            ss_q     <= 8'hFF;
            en_q     <= 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (Wr) begin
                case (Addr)
                    A_CTRL: en_q <= DataWr[0];
                    A_CFG:  cfg_q <= DataWr;
                    A_SS:   ss_q <= DataWr;
                    default: begin
                        buf_q    <= DataWr ^ key;
                        busy_cnt <= busy_len;
                    end
                endcase
            end
        end
    end
    assign DataRd = (Addr == A_CTRL) ? {(stuck || busy_cnt != 0), 6'b000000, en_q} :
                    (Addr == A_CFG)  ? cfg_q :
                    (Addr == A_SS)   ? ss_q : buf_q;

    // bus write log and Ack counters
    always @(negedge Clk) begin
        if (Wr) wlog.push_back({Addr, DataWr});
        if (Ack0) ack0_cnt++;
        if (Ack1) ack1_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // POLL cycles for a transfer that stays busy len cycles after the BUFFER write
    function automatic int kpoll(input int len);
        return (len <= S) ? 1 : len - S + 1;
    endfunction

    task automatic single(input int p, input logic [2:0] sl, input logic [1:0] md,
                          input logic [3:0] pr, input logic [7:0] tx, input int len, input bit stk);
        int         n, exp_n, a0, a1;
        logic [7:0] exp_rx;
        logic       got;
        exp_n  = stk ? (5 + S + T) : (7 + S + kpoll(len));
        exp_rx = stk ? 8'h00 : (tx ^ key);
        @(negedge Clk);
        wlog.delete();
        a0 = ack0_cnt;
        a1 = ack1_cnt;
        busy_len = len;
        stuck = stk;
        if (p == 0) begin
            Slave0 = sl; Mode0 = md; Pre0 = pr; Tx0 = tx; Req0 = 1'b1;
        end else begin
            Slave1 = sl; Mode1 = md; Pre1 = pr; Tx1 = tx; Req1 = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge Clk);
            n++;
            if (n == 2) begin
                if (p == 0) begin
                    Slave0 = 3'($urandom); Mode0 = 2'($urandom); Pre0 = 4'($urandom); Tx0 = 8'($urandom);
                end else begin
                    Slave1 = 3'($urandom); Mode1 = 2'($urandom); Pre1 = 4'($urandom); Tx1 = 8'($urandom);
                end
            end
            got = (p == 0) ? Ack0 : Ack1;
        end
        check_eq("ack_latency", 32'(n), 32'(exp_n));
        check_eq("rx", 32'((p == 0) ? Rx0 : Rx1), 32'(exp_rx));
        check_eq("err", 32'((p == 0) ? Err0 : Err1), 32'(stk));
        check_eq("grant_done", 32'(Grant), (p == 0) ? 32'd1 : 32'd2);
        if (p == 0) Req0 = 1'b0; else Req1 = 1'b0;
        stuck = 1'b0;
        @(negedge Clk);
        check_eq("busy_after", 32'(Busy), 32'd0);
        check_eq("own_acks", 32'((p == 0) ? ack0_cnt - a0 : ack1_cnt - a1), 32'd1);
        check_eq("other_acks", 32'((p == 0) ? ack1_cnt - a1 : ack0_cnt - a0), 32'd0);
        check_eq("n_writes", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check_eq("wr_config", 32'(wlog[0]), 32'({A_CFG, 2'b00, md, pr}));
            check_eq("wr_ssel", 32'(wlog[1]), 32'({A_SS, ~(8'b1 << sl)}));
            check_eq("wr_buffer", 32'(wlog[2]), 32'({A_BUF, tx}));
            check_eq("wr_desel", 32'(wlog[3]), 32'({A_SS, 8'hFF}));
        end
        last_served = p;
    endtask

    task automatic pair(input int len);
        int         n, d, a0n, a1n, first;
        logic [7:0] t0, t1;
        t0 = 8'($urandom);
        t1 = 8'($urandom);
        first = (last_served == 1) ? 0 : 1;
        d = 7 + S + kpoll(len);
        @(negedge Clk);
        busy_len = len;
        Slave0 = 3'($urandom); Mode0 = 2'($urandom); Pre0 = 4'($urandom); Tx0 = t0;
        Slave1 = 3'($urandom); Mode1 = 2'($urandom); Pre1 = 4'($urandom); Tx1 = t1;
        Req0 = 1'b1;
        Req1 = 1'b1;
        n = 0; a0n = 0; a1n = 0;
        while ((a0n == 0 || a1n == 0) && n < 400) begin
            @(negedge Clk);
            n++;
            if (Ack0 && a0n == 0) begin
                a0n = n;
                check_eq("pair_rx0", 32'(Rx0), 32'(t0 ^ key));
                Req0 = 1'b0;
            end
            if (Ack1 && a1n == 0) begin
                a1n = n;
                check_eq("pair_rx1", 32'(Rx1), 32'(t1 ^ key));
                Req1 = 1'b0;
            end
        end
        check_eq("pair_first_lat", 32'((first == 0) ? a0n : a1n), 32'(d));
        check_eq("pair_second_lat", 32'((first == 0) ? a1n : a0n), 32'(2 * d + 1));
        check_eq("pair_rx_held", 32'((first == 0) ? Rx0 : Rx1), 32'((first == 0) ? (t0 ^ key) : (t1 ^ key)));
        Req0 = 1'b0;
        Req1 = 1'b0;
        last_served = 1 - first;
    endtask

    task automatic reset_mid();
        int   n, a0;
        logic got;
        @(negedge Clk);
        busy_len = 1;
        stuck = 1'b1;
        Slave0 = 3'd2; Mode0 = 2'd1; Pre0 = 4'd3; Tx0 = 8'h3C;
        Req0 = 1'b1;
        repeat (4 + S + 3) @(negedge Clk);
        check_eq("mid_busy", 32'(Busy), 32'd1);
        check_eq("mid_grant", 32'(Grant), 32'd1);
        a0 = ack0_cnt;
        #2 Rst = 1'b1;
        #1;
        check_eq("async_wr", 32'(Wr), 32'd0);
        check_eq("async_grant", 32'(Grant), 32'd0);
        check_eq("async_busy", 32'(Busy), 32'd0);
        stuck = 1'b0;
        busy_len = 3;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        last_served = 1;
        @(negedge Clk);
        check_eq("reinit_wr", 32'(Wr), 32'd1);
        check_eq("reinit_addr", 32'(Addr), 32'(A_CTRL));
        check_eq("reinit_data", 32'(DataWr), 32'h01);
        check_eq("no_abort_ack", 32'(ack0_cnt - a0), 32'd0);
        n = 1;
        got = Ack0;
        while (!got && n < 200) begin
            @(negedge Clk);
            n++;
            got = Ack0;
        end
        check_eq("reserve_lat", 32'(n), 32'(1 + 7 + S + kpoll(3)));
        check_eq("reserve_rx", 32'(Rx0), 32'(8'h3C ^ key));
        check_eq("reserve_err", 32'(Err0), 32'd0);
        Req0 = 1'b0;
        last_served = 0;
        @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0;
        Slave0 = '0; Slave1 = '0; Mode0 = '0; Mode1 = '0;
        Pre0 = '0; Pre1 = '0; Tx0 = '0; Tx1 = '0;
        key = 8'($urandom);
        repeat (3) @(negedge Clk);
        check_eq("rst_wr", 32'(Wr), 32'd0);
        check_eq("rst_addr_data", 32'({Addr, DataWr}), 32'd0);
        check_eq("rst_ack_err", 32'({Ack0, Ack1, Err0, Err1}), 32'd0);
        check_eq("rst_rx", 32'({Rx0, Rx1}), 32'd0);
        check_eq("rst_grant_busy", 32'({Grant, Busy}), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        check_eq("init_wr", 32'(Wr), 32'd1);
        check_eq("init_addr", 32'(Addr), 32'(A_CTRL));
        check_eq("init_data", 32'(DataWr), 32'h01);
        repeat (3) begin
            @(negedge Clk);
            check_eq("idle_wr", 32'(Wr), 32'd0);
            check_eq("idle_busy", 32'(Busy), 32'd0);
        end

        for (int m = 0; m < 4; m++)
            single(0, 3'd0, 2'(m), 4'd1, 8'hBB, int'($urandom_range(6, 1)), 1'b0);
        single(1, 3'd5, 2'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(6, 1)), 1'b0);

        pair(2);
        pair(5);

        single(0, 3'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), 1, 1'b1);

        for (int i = 0; i < 6; i++)
            single(int'($urandom_range(1, 0)), 3'($urandom), 2'($urandom), 4'($urandom),
                   8'($urandom), int'($urandom_range(8, 1)), 1'b0);

        reset_mid();
        single(1, 3'd7, 2'd3, 4'hF, 8'h81, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
